matmul_sequencer: RTL and testbench
===================================

Name: matmul_sequencer

Overview:
Top-level control FSM for one systolic-array GEMM pass, with the array sized SYS_ROWS x SYS_COLS.
- For each of num_tiles K-tiles it preloads a weight tile, then streams A_ROWS activation rows through the array.
- It then waits out the array skew and writes partial sums to the accumulator, overwriting on tile 0 and accumulating on later tiles.
- After the last tile it drains the accumulator to the output port under a valid/ready handshake.
- It sits between the instruction decoder (start/num_tiles) and the weight buffer, input buffer, array and accumulator.

Parameters:
SYS_ROWS, 50, array rows; also the weight rows per tile.
SYS_COLS, 50, array columns.
A_ROWS, 50, activation rows per tile; also the accumulator depth.
PIPE_LAT, SYS_ROWS+SYS_COLS-1, cycles from a_rd_en to the matching result row at the array output.
TILE_W, 8, width of num_tiles.
ADDR_W, 16, buffer address width.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  start request; sampled only in IDLE
num_tiles  in  TILE_W  K-tile count, latched on start
busy  out  1  high from the first cycle after an accepted start through DONE, inclusive
done  out  1  one-cycle pulse in the DONE state
w_rd_en  out  1  weight buffer read / shift into array
w_rd_addr  out  ADDR_W  tile*SYS_ROWS + row
a_rd_en  out  1  activation buffer read / inject row into array
a_rd_addr  out  ADDR_W  tile*A_ROWS + row
acc_wr_en  out  1  result row valid at array output; write it
acc_wr_addr  out  ADDR_W  result row index, 0..A_ROWS-1
acc_accumulate  out  1  0 = overwrite (tile 0), 1 = add; aligned with acc_wr_en
tile_idx  out  TILE_W  current tile
out_valid  out  1  drain beat valid
out_ready  in  1  downstream accepts a drain beat
acc_rd_addr  out  ADDR_W  accumulator row being drained

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; counters, latched num_tiles and the delay line cleared. Reset mid-operation abandons the pass; no done pulse is issued.
- States and transitions:
  - IDLE: on start=1 with num_tiles>0, latch num_tiles, set tile_idx=0, go to LOAD_W.
  - IDLE: on start=1 with num_tiles=0, go straight to DONE with no buffer activity.
  - LOAD_W: SYS_ROWS cycles, w_rd_en=1, row counts 0..SYS_ROWS-1, then STREAM.
  - STREAM: A_ROWS cycles, a_rd_en=1, row counts 0..A_ROWS-1, then FLUSH.
  - FLUSH: PIPE_LAT cycles. If tile_idx < num_tiles-1, increment tile_idx and go to LOAD_W; otherwise go to DRAIN.
  - DRAIN: out_valid=1 with acc_rd_addr = row. A beat completes on out_valid & out_ready and the row advances. After beat A_ROWS-1 completes, go to DONE. While out_ready=0, acc_rd_addr and out_valid are held.
  - DONE: done=1 and busy=1 for one cycle, then IDLE.
- Result alignment:
  - acc_wr_en, acc_wr_addr and acc_accumulate come from a PIPE_LAT-deep shift register fed by a_rd_en, the row counter and (tile_idx!=0).
  - The last write therefore lands in the final FLUSH cycle.
  - Weight loading of tile t+1 never overlaps result writes of tile t.
- Cycle count per tile: SYS_ROWS + A_ROWS + PIPE_LAT. Drain takes A_ROWS cycles plus stall cycles.
- start while busy: ignored, not queued.
- Address arithmetic: unsigned, truncated to ADDR_W. Bounding tile*SYS_ROWS within ADDR_W is the caller's responsibility.
- Counters wrap to 0 at phase exit. tile_idx holds its final value until the next accepted start.

Decomposition:
- Package: state enum typedef, counter width from $clog2(max(SYS_ROWS, A_ROWS, PIPE_LAT)), and default geometry constants shared with the array and buffers.
- Sub-module: result_delay_line, a parameterised-depth shift register with async active-low clear. It carries {valid, row, accumulate}.

Test Plan:
All scenarios use SYS_ROWS=4, SYS_COLS=4, A_ROWS=3, PIPE_LAT=7, out_ready=1, with start accepted at edge k unless stated otherwise.
1. num_tiles=1 -> w_rd_en k+1..k+4 (addr 0..3); a_rd_en k+5..k+7 (addr 0..2); acc_wr_en k+12..k+14 (addr 0..2, accumulate=0); out_valid k+15..k+17; done at k+18; busy low at k+19.
2. num_tiles=2 -> second LOAD_W k+15..k+18 with w_rd_addr 4..7; a_rd_addr 3..5; acc_wr_en k+26..k+28 with accumulate=1; done at k+32.
3. num_tiles=0 -> done at k+1; no rd/wr enables ever asserted.
4. num_tiles=1 with out_ready held low for 3 cycles at the start of DRAIN -> acc_rd_addr stays 0 and out_valid stays 1 during the stall; done at k+21.
5. rst_n pulsed low at k+6 (mid-STREAM) -> all outputs 0 asynchronously; IDLE after release; a new start runs the full scenario-1 timing.
6. start re-asserted at k+3 while busy -> ignored; timing identical to scenario 1.

Source files
------------

// File: rtl/matmul_sequencer_pkg.sv
// rtl/matmul_sequencer_pkg.sv - shared state encoding and geometry defaults for the GEMM sequencer
package matmul_sequencer_pkg;

  localparam int DEF_SYS_ROWS = 50;
  localparam int DEF_SYS_COLS = 50;
  localparam int DEF_A_ROWS   = 50;
  localparam int DEF_TILE_W   = 8;
  localparam int DEF_ADDR_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_STREAM,
    ST_FLUSH,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // One shared phase counter must reach the longest of the three phase lengths.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/matmul_sequencer_result_delay_line.sv
// rtl/matmul_sequencer_result_delay_line.sv - fixed-depth shift register aligning result-row tags with the array output
module result_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/matmul_sequencer.sv
// rtl/matmul_sequencer.sv - control FSM for one systolic-array GEMM pass: weight load, stream, flush, drain
module matmul_sequencer
  import matmul_sequencer_pkg::*;
#(
  parameter int SYS_ROWS = DEF_SYS_ROWS,
  parameter int SYS_COLS = DEF_SYS_COLS,
  parameter int A_ROWS   = DEF_A_ROWS,
  parameter int PIPE_LAT = SYS_ROWS + SYS_COLS - 1,
  parameter int TILE_W   = DEF_TILE_W,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [TILE_W-1:0] num_tiles,
  output logic              busy,
  output logic              done,
  output logic              w_rd_en,
  output logic [ADDR_W-1:0] w_rd_addr,
  output logic              a_rd_en,
  output logic [ADDR_W-1:0] a_rd_addr,
  output logic              acc_wr_en,
  output logic [ADDR_W-1:0] acc_wr_addr,
  output logic              acc_accumulate,
  output logic [TILE_W-1:0] tile_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] acc_rd_addr
);

  localparam int CNT_W = cnt_width(SYS_ROWS, A_ROWS, PIPE_LAT);
  localparam int DL_W  = CNT_W + 2;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  row_q, row_d;
  logic [TILE_W-1:0] tile_q, tile_d;
  logic [TILE_W-1:0] num_q, num_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              w_rd_en_q, w_rd_en_d;
  logic [ADDR_W-1:0] w_rd_addr_q, w_rd_addr_d;
  logic              a_rd_en_q, a_rd_en_d;
  logic [ADDR_W-1:0] a_rd_addr_q, a_rd_addr_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] acc_rd_addr_q, acc_rd_addr_d;
  logic [DL_W-1:0]   dl_in, dl_out;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    tile_d  = tile_q;
    num_d   = num_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_d   = num_tiles;
          tile_d  = '0;
          row_d   = '0;
          state_d = (num_tiles != '0) ? ST_LOAD_W : ST_DONE;
        end
      end
      ST_LOAD_W: begin
        if (row_q == CNT_W'(SYS_ROWS - 1)) begin
          row_d   = '0;
          state_d = ST_STREAM;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      ST_STREAM: begin
        if (row_q == CNT_W'(A_ROWS - 1)) begin
          row_d   = '0;
          state_d = ST_FLUSH;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      ST_FLUSH: begin
        if (row_q == CNT_W'(PIPE_LAT - 1)) begin
          row_d = '0;
          // Widened compare avoids underflow of num_tiles-1.
          if (({1'b0, tile_q} + (TILE_W+1)'(1)) < {1'b0, num_q}) begin
            tile_d  = tile_q + 1'b1;
            state_d = ST_LOAD_W;
          end else begin
            state_d = ST_DRAIN;
          end
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (row_q == CNT_W'(A_ROWS - 1)) begin
            row_d   = '0;
            state_d = ST_DONE;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Outputs are computed from the next state so they register alongside it.
    busy_d        = (state_d != ST_IDLE);
    done_d        = (state_d == ST_DONE);
    w_rd_en_d     = (state_d == ST_LOAD_W);
    a_rd_en_d     = (state_d == ST_STREAM);
    out_valid_d   = (state_d == ST_DRAIN);
    w_rd_addr_d   = w_rd_en_d ? ADDR_W'(tile_d) * ADDR_W'(SYS_ROWS) + ADDR_W'(row_d) : '0;
    a_rd_addr_d   = a_rd_en_d ? ADDR_W'(tile_d) * ADDR_W'(A_ROWS) + ADDR_W'(row_d) : '0;
    acc_rd_addr_d = out_valid_d ? ADDR_W'(row_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      row_q         <= '0;
      tile_q        <= '0;
      num_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      w_rd_en_q     <= 1'b0;
      w_rd_addr_q   <= '0;
      a_rd_en_q     <= 1'b0;
      a_rd_addr_q   <= '0;
      out_valid_q   <= 1'b0;
      acc_rd_addr_q <= '0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      tile_q        <= tile_d;
      num_q         <= num_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      w_rd_en_q     <= w_rd_en_d;
      w_rd_addr_q   <= w_rd_addr_d;
      a_rd_en_q     <= a_rd_en_d;
      a_rd_addr_q   <= a_rd_addr_d;
      out_valid_q   <= out_valid_d;
      acc_rd_addr_q <= acc_rd_addr_d;
    end
  end

  // row_q is aligned with a_rd_en_q, so it tags the row entering the array this cycle.
  assign dl_in = {a_rd_en_q, a_rd_en_q ? row_q : CNT_W'(0), a_rd_en_q && (tile_q != '0)};

  result_delay_line #(
    .DEPTH (PIPE_LAT),
    .WIDTH (DL_W)
  ) u_result_delay_line (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (dl_in),
    .dout  (dl_out)
  );

  assign acc_wr_en      = dl_out[DL_W-1];
  assign acc_wr_addr    = ADDR_W'(dl_out[DL_W-2:1]);
  assign acc_accumulate = dl_out[0];
  assign busy           = busy_q;
  assign done           = done_q;
  assign w_rd_en        = w_rd_en_q;
  assign w_rd_addr      = w_rd_addr_q;
  assign a_rd_en        = a_rd_en_q;
  assign a_rd_addr      = a_rd_addr_q;
  assign out_valid      = out_valid_q;
  assign acc_rd_addr    = acc_rd_addr_q;
  assign tile_idx       = tile_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb/tb_matmul_sequencer.sv - self-checking bench for matmul_sequencer against a schedule-level reference model
module tb_matmul_sequencer;

  localparam int SR   = 4;
  localparam int SC   = 4;
  localparam int AR   = 3;
  localparam int PL   = SR + SC - 1;
  localparam int TW   = 8;
  localparam int AW   = 16;
  localparam int TILE = SR + AR + PL;
  localparam int MAXC = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [TW-1:0] num_tiles = '0;
  logic          out_ready = 1'b1;
  logic          busy, done, w_rd_en, a_rd_en, acc_wr_en, acc_accumulate, out_valid;
  logic [AW-1:0] w_rd_addr, a_rd_addr, acc_wr_addr, acc_rd_addr;
  logic [TW-1:0] tile_idx;

  int errors = 0;
  int checks = 0;

  bit e_busy [MAXC], e_done [MAXC], e_wen [MAXC], e_aen [MAXC];
  bit e_accen [MAXC], e_accum [MAXC], e_oval [MAXC];
  int e_waddr [MAXC], e_aaddr [MAXC], e_accaddr [MAXC], e_rdaddr [MAXC], e_tile [MAXC];
  bit rdy [MAXC];
  int last_c;

  matmul_sequencer #(
    .SYS_ROWS (SR), .SYS_COLS (SC), .A_ROWS (AR), .PIPE_LAT (PL), .TILE_W (TW), .ADDR_W (AW)
  ) dut (
    .clk (clk), .rst_n (rst_n), .start (start), .num_tiles (num_tiles),
    .busy (busy), .done (done),
    .w_rd_en (w_rd_en), .w_rd_addr (w_rd_addr),
    .a_rd_en (a_rd_en), .a_rd_addr (a_rd_addr),
    .acc_wr_en (acc_wr_en), .acc_wr_addr (acc_wr_addr), .acc_accumulate (acc_accumulate),
    .tile_idx (tile_idx), .out_valid (out_valid), .out_ready (out_ready),
    .acc_rd_addr (acc_rd_addr)
  );

  always #5 clk = ~clk;

  // Cycle 1 is the first cycle after the accepting edge; fills expectations up to the first idle cycle.
  task automatic build_model(input int t_cnt);
    int c, beats, base;
    for (int j = 0; j < MAXC; j++) begin
      e_busy[j] = 0; e_done[j] = 0; e_wen[j] = 0; e_aen[j] = 0;
      e_accen[j] = 0; e_accum[j] = 0; e_oval[j] = 0;
      e_waddr[j] = 0; e_aaddr[j] = 0; e_accaddr[j] = 0; e_rdaddr[j] = 0;
      e_tile[j] = (t_cnt == 0) ? 0 : (((j - 1) / TILE < t_cnt - 1) ? (j - 1) / TILE : t_cnt - 1);
    end
    for (int t = 0; t < t_cnt; t++) begin
      base = 1 + t * TILE;
      for (int r = 0; r < SR; r++) begin
        e_wen[base + r] = 1; e_waddr[base + r] = t * SR + r;
      end
      for (int r = 0; r < AR; r++) begin
        e_aen[base + SR + r] = 1; e_aaddr[base + SR + r] = t * AR + r;
        e_accen[base + SR + r + PL] = 1;
        e_accaddr[base + SR + r + PL] = r;
        e_accum[base + SR + r + PL] = (t != 0);
      end
    end
    c = 1;
    if (t_cnt > 0) begin
      c = 1 + t_cnt * TILE;
      beats = 0;
      while (beats < AR && c < MAXC - 2) begin
        e_oval[c] = 1; e_rdaddr[c] = beats;
        if (rdy[c]) beats++;
        c++;
      end
    end
    e_done[c] = 1;
    for (int j = 1; j <= c; j++) e_busy[j] = 1;
    last_c = c + 1;
  endtask

  task automatic run_pass(input int t_cnt, input int restart_at, input string name);
    @(negedge clk);
    start = 1'b1; num_tiles = TW'(t_cnt);
    @(posedge clk);
    #1 start = 1'b0;
    for (int j = 1; j <= last_c; j++) begin
      @(negedge clk);
      out_ready = rdy[j];
      start = (j == restart_at);
      num_tiles = (j == restart_at) ? TW'(5) : TW'(t_cnt);
      checks++;
      if (busy !== e_busy[j]) begin errors++; $display("FAIL %s busy c%0d got %b want %b", name, j, busy, e_busy[j]); end
      checks++;
      if (done !== e_done[j]) begin errors++; $display("FAIL %s done c%0d got %b want %b", name, j, done, e_done[j]); end
      checks++;
      if (w_rd_en !== e_wen[j]) begin errors++; $display("FAIL %s w_rd_en c%0d got %b want %b", name, j, w_rd_en, e_wen[j]); end
      checks++;
      if (a_rd_en !== e_aen[j]) begin errors++; $display("FAIL %s a_rd_en c%0d got %b want %b", name, j, a_rd_en, e_aen[j]); end
      checks++;
      if (acc_wr_en !== e_accen[j]) begin errors++; $display("FAIL %s acc_wr_en c%0d got %b want %b", name, j, acc_wr_en, e_accen[j]); end
      checks++;
      if (out_valid !== e_oval[j]) begin errors++; $display("FAIL %s out_valid c%0d got %b want %b", name, j, out_valid, e_oval[j]); end
      checks++;
      if (int'(tile_idx) !== e_tile[j]) begin errors++; $display("FAIL %s tile_idx c%0d got %0d want %0d", name, j, tile_idx, e_tile[j]); end
      if (e_wen[j]) begin
        checks++;
        if (int'(w_rd_addr) !== e_waddr[j]) begin errors++; $display("FAIL %s w_rd_addr c%0d got %0d want %0d", name, j, w_rd_addr, e_waddr[j]); end
      end
      if (e_aen[j]) begin
        checks++;
        if (int'(a_rd_addr) !== e_aaddr[j]) begin errors++; $display("FAIL %s a_rd_addr c%0d got %0d want %0d", name, j, a_rd_addr, e_aaddr[j]); end
      end
      if (e_accen[j]) begin
        checks++;
        if (int'(acc_wr_addr) !== e_accaddr[j]) begin errors++; $display("FAIL %s acc_wr_addr c%0d got %0d want %0d", name, j, acc_wr_addr, e_accaddr[j]); end
        checks++;
        if (acc_accumulate !== e_accum[j]) begin errors++; $display("FAIL %s acc_accumulate c%0d got %b want %b", name, j, acc_accumulate, e_accum[j]); end
      end
      if (e_oval[j]) begin
        checks++;
        if (int'(acc_rd_addr) !== e_rdaddr[j]) begin errors++; $display("FAIL %s acc_rd_addr c%0d got %0d want %0d", name, j, acc_rd_addr, e_rdaddr[j]); end
      end
    end
    start = 1'b0; out_ready = 1'b1;
  endtask

  task automatic all_ready();
    for (int j = 0; j < MAXC; j++) rdy[j] = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({busy, done, w_rd_en, a_rd_en, acc_wr_en, acc_accumulate, out_valid} !== 7'b0) begin
      errors++; $display("FAIL reset flags got %b want 0", {busy, done, w_rd_en, a_rd_en, acc_wr_en, acc_accumulate, out_valid});
    end
    checks++;
    if ({w_rd_addr, a_rd_addr, acc_wr_addr, acc_rd_addr, tile_idx} !== '0) begin
      errors++; $display("FAIL reset addrs got %h want 0", {w_rd_addr, a_rd_addr, acc_wr_addr, acc_rd_addr, tile_idx});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_tile();
    all_ready(); build_model(1); run_pass(1, 0, "single_tile");
  endtask

  task automatic test_two_tiles();
    all_ready(); build_model(2); run_pass(2, 0, "two_tiles");
  endtask

  task automatic test_zero_tiles();
    all_ready(); build_model(0); run_pass(0, 0, "zero_tiles");
  endtask

  task automatic test_drain_stall();
    all_ready();
    for (int j = 15; j <= 17; j++) rdy[j] = 1'b0;
    build_model(1); run_pass(1, 0, "drain_stall");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; num_tiles = TW'(1);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, w_rd_en, a_rd_en, acc_wr_en, acc_accumulate, out_valid} !== 7'b0) begin
      errors++; $display("FAIL reset_mid flags got %b want 0", {busy, done, w_rd_en, a_rd_en, acc_wr_en, acc_accumulate, out_valid});
    end
    checks++;
    if ({w_rd_addr, a_rd_addr, acc_wr_addr, acc_rd_addr, tile_idx} !== '0) begin
      errors++; $display("FAIL reset_mid addrs got %h want 0", {w_rd_addr, a_rd_addr, acc_wr_addr, acc_rd_addr, tile_idx});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      checks++;
      if ({busy, done, acc_wr_en} !== 3'b0) begin errors++; $display("FAIL reset_mid idle got %b want 0", {busy, done, acc_wr_en}); end
    end
    all_ready(); build_model(1); run_pass(1, 0, "after_reset");
  endtask

  task automatic test_start_while_busy();
    all_ready(); build_model(1); run_pass(1, 3, "start_while_busy");
  endtask

  task automatic test_random();
    int t_cnt;
    for (int n = 0; n < 6; n++) begin
      t_cnt = int'($urandom_range(0, 3));
      for (int j = 0; j < MAXC; j++) rdy[j] = ($urandom_range(0, 2) != 0) || (j >= 150);
      build_model(t_cnt);
      run_pass(t_cnt, 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_two_tiles();
    test_zero_tiles();
    test_drain_stall();
    test_reset_mid();
    test_start_while_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
